// File: rtl/pulse_seq_gen.sv
// rtl/pulse_seq_gen.sv - period-locked P1 + CPMG echo sequencer with sync, inhibit and attenuator outputs
// Optional feature macro: PULSE_PHASE_EN (adds cfg_alt input and phase_out output).
module pulse_seq_gen #(
    parameter int CW     = 32,
    parameter int NW     = 8,
    parameter int AW     = 7,
    parameter int SYNC_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_p1width,
    input  logic [CW-1:0] cfg_delay,
    input  logic [CW-1:0] cfg_p2width,
    input  logic [NW-1:0] cfg_npulse,
    input  logic [CW-1:0] cfg_block_off,
    input  logic [AW-1:0] cfg_pre_att,
    input  logic [AW-1:0] cfg_post_att,
    output logic          sync_out,
    output logic          pulse_out,
    output logic          inhib_out,
    output logic [AW-1:0] att_out,
    output logic          cycle_done,
`ifdef PULSE_PHASE_EN
    input  logic          cfg_alt,
    output logic [1:0]    phase_out,
`endif
    output logic          err_overrun
);
    typedef enum logic [2:0] {S_IDLE, S_P1, S_GAP, S_P2, S_GAP2, S_WAIT} state_t;
    typedef struct packed {
        state_t      st;
        logic [CW:0] left;
    } step_t;

    logic [CW-1:0] r_s_period, r_s_p1width, r_s_delay, r_s_p2width, r_s_block_off;
    logic [NW-1:0] r_s_npulse;
    logic [AW-1:0] r_s_pre_att, r_s_post_att;
    logic [CW-1:0] r_a_period, r_a_p1width, r_a_delay, r_a_p2width, r_a_block_off;
    logic [NW-1:0] r_a_npulse;
    logic [AW-1:0] r_a_pre_att, r_a_post_att;

    logic          r_running;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [CW:0]   r_left;
    logic [NW-1:0] r_echo;
    logic [CW-1:0] r_boff;
    logic          r_sync, r_pulse, r_inhib, r_done, r_err;
    logic [AW-1:0] r_att;

    logic          w_wrap, w_take, w_run_nx, w_ovr;
    logic [CW-1:0] w_period, w_p1width, w_delay, w_p2width, w_block_off;
    logic [NW-1:0] w_npulse;
    logic [AW-1:0] w_pre_att, w_post_att;
    logic [CW-1:0] w_cnt_nx, w_boff_nx;
    step_t         w_adv, w_nx;
    logic [NW-1:0] w_adv_echo, w_echo_nx;

    // Zero-width echoes count as no echoes, so the whole train (and its lead-in gap) vanishes.
    function automatic step_t after_p1(input logic [NW-1:0] np, input logic [CW-1:0] dly,
                                       input logic [CW-1:0] p2w);
        step_t s;
        s.st   = S_WAIT;
        s.left = '0;
        if (np != '0 && p2w != '0) begin
            if (dly != '0) begin
                s.st   = S_GAP;
                s.left = {1'b0, dly};
            end else begin
                s.st   = S_P2;
                s.left = {1'b0, p2w};
            end
        end
        return s;
    endfunction

    assign w_wrap      = r_running && (r_cnt == r_a_period - CW'(1));
    assign w_take      = !r_running || w_wrap;
    assign w_period    = w_take ? r_s_period    : r_a_period;
    assign w_p1width   = w_take ? r_s_p1width   : r_a_p1width;
    assign w_delay     = w_take ? r_s_delay     : r_a_delay;
    assign w_p2width   = w_take ? r_s_p2width   : r_a_p2width;
    assign w_npulse    = w_take ? r_s_npulse    : r_a_npulse;
    assign w_block_off = w_take ? r_s_block_off : r_a_block_off;
    assign w_pre_att   = w_take ? r_s_pre_att   : r_a_pre_att;
    assign w_post_att  = w_take ? r_s_post_att  : r_a_post_att;
    assign w_run_nx    = enable && (w_period >= CW'(2));
    assign w_ovr       = w_wrap && (w_adv.st != S_WAIT);

    always_comb begin
        w_adv.st   = r_state;
        w_adv.left = r_left - (CW+1)'(1);
        w_adv_echo = r_echo;
        if (r_state != S_IDLE && r_state != S_WAIT && r_left <= (CW+1)'(1)) begin
            case (r_state)
                S_P1: w_adv = after_p1(r_a_npulse, r_a_delay, r_a_p2width);
                S_GAP: begin
                    w_adv.st   = S_P2;
                    w_adv.left = {1'b0, r_a_p2width};
                end
                S_P2: begin
                    if ({1'b0, r_echo} + (NW+1)'(1) < {1'b0, r_a_npulse}) begin
                        if (r_a_delay != '0) begin
                            w_adv.st   = S_GAP2;
                            w_adv.left = {r_a_delay, 1'b0};
                        end else begin
                            w_adv.st   = S_P2;
                            w_adv.left = {1'b0, r_a_p2width};
                            w_adv_echo = r_echo + NW'(1);
                        end
                    end else begin
                        w_adv.st   = S_WAIT;
                        w_adv.left = '0;
                    end
                end
                S_GAP2: begin
                    w_adv.st   = S_P2;
                    w_adv.left = {1'b0, r_a_p2width};
                    w_adv_echo = r_echo + NW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nx.st   = S_IDLE;
        w_nx.left = '0;
        w_echo_nx = '0;
        w_cnt_nx  = '0;
        if (w_run_nx) begin
            if (w_take) begin
                if (w_p1width != '0) begin
                    w_nx.st   = S_P1;
                    w_nx.left = {1'b0, w_p1width};
                end else begin
                    w_nx = after_p1(w_npulse, w_delay, w_p2width);
                end
            end else begin
                w_nx      = w_adv;
                w_echo_nx = w_adv_echo;
                w_cnt_nx  = r_cnt + CW'(1);
            end
        end
        w_boff_nx = '0;
        if (w_nx.st == S_WAIT) begin
            if (w_take || r_state != S_WAIT) w_boff_nx = w_block_off;
            else if (r_boff != '0)           w_boff_nx = r_boff - CW'(1);
        end
    end

`ifdef PULSE_PHASE_EN
    logic       r_s_alt, r_a_alt, w_alt;
    logic [1:0] r_phase, w_phase_nx;

    assign w_alt = w_take ? r_s_alt : r_a_alt;

    // Gaps hold the phase of the preceding pulse so it is already settled at the next edge.
    always_comb begin
        w_phase_nx = 2'd0;
        case (w_nx.st)
            S_P2:         w_phase_nx = (w_alt && w_echo_nx[0]) ? 2'd3 : 2'd1;
            S_GAP, S_GAP2: w_phase_nx = w_take ? 2'd0 : r_phase;
            default:      w_phase_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s_alt <= 1'b0;
            r_a_alt <= 1'b0;
            r_phase <= 2'd0;
        end else begin
            if (cfg_load) r_s_alt <= cfg_alt;
            if (w_take)   r_a_alt <= w_alt;
            r_phase <= w_phase_nx;
        end
    end

    assign phase_out = r_phase;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s_period <= '0; r_s_p1width <= '0; r_s_delay <= '0; r_s_p2width <= '0;
            r_s_block_off <= '0; r_s_npulse <= '0; r_s_pre_att <= '0; r_s_post_att <= '0;
            r_a_period <= '0; r_a_p1width <= '0; r_a_delay <= '0; r_a_p2width <= '0;
            r_a_block_off <= '0; r_a_npulse <= '0; r_a_pre_att <= '0; r_a_post_att <= '0;
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
            r_left    <= '0;
            r_echo    <= '0;
            r_boff    <= '0;
            r_sync    <= 1'b0;
            r_pulse   <= 1'b0;
            r_inhib   <= 1'b0;
            r_att     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_s_period <= cfg_period; r_s_p1width <= cfg_p1width; r_s_delay <= cfg_delay;
                r_s_p2width <= cfg_p2width; r_s_block_off <= cfg_block_off; r_s_npulse <= cfg_npulse;
                r_s_pre_att <= cfg_pre_att; r_s_post_att <= cfg_post_att;
            end
            if (w_take) begin
                r_a_period <= w_period; r_a_p1width <= w_p1width; r_a_delay <= w_delay;
                r_a_p2width <= w_p2width; r_a_block_off <= w_block_off; r_a_npulse <= w_npulse;
                r_a_pre_att <= w_pre_att; r_a_post_att <= w_post_att;
            end
            r_running <= w_run_nx;
            r_cnt     <= w_cnt_nx;
            r_state   <= w_nx.st;
            r_left    <= w_nx.left;
            r_echo    <= w_echo_nx;
            r_boff    <= w_boff_nx;
            r_pulse   <= (w_nx.st == S_P1) || (w_nx.st == S_P2);
            r_sync    <= w_run_nx && (w_cnt_nx < CW'(SYNC_W));
            r_inhib   <= (w_nx.st != S_IDLE && w_nx.st != S_WAIT) || (w_boff_nx != '0);
            r_att     <= (w_nx.st == S_WAIT) ? w_post_att : (w_nx.st == S_IDLE) ? '0 : w_pre_att;
            r_done    <= w_run_nx && (w_cnt_nx == w_period - CW'(1));
            if (w_ovr)         r_err <= 1'b1;
            else if (cfg_load) r_err <= 1'b0;
        end
    end

    assign sync_out    = r_sync;
    assign pulse_out   = r_pulse;
    assign inhib_out   = r_inhib;
    assign att_out     = r_att;
    assign cycle_done  = r_done;
    assign err_overrun = r_err;
endmodule

// File: doc/pulse_seq_gen.md
Name: pulse_seq_gen

Overview:
- Parametrised successor of the single-shot pulse generator: one period counter drives a sync marker, a p1 pulse, and a programmable CPMG echo train of N p2 pulses.
- Also drives a receiver-blanking (inhibit) window and pre/post attenuator codes.
- Configuration is double-buffered: a shadow set is loaded at any time and applied only at a period boundary, so reprogramming never produces a truncated or glitched sequence.
- Sits between the UART command decoder and the output pins.

Parameters:
- CW, 32: width of all timing fields and the period counter (clk cycles).
- NW, 8: width of the echo-count field.
- AW, 7: attenuator code width.
- SYNC_W, 16: sync_out high time in cycles (must be < 2^CW).

Ports:
- clk  in  1  pulse clock (PLL domain).
- resetn  in  1  reset.
- enable  in  1  run when high.
- cfg_load  in  1  single-cycle strobe; captures all cfg_* inputs into the shadow set.
- cfg_period  in  CW  period length in cycles.
- cfg_p1width  in  CW  first-pulse width.
- cfg_delay  in  CW  p1-to-first-echo gap; echo gaps are 2*delay.
- cfg_p2width  in  CW  echo pulse width.
- cfg_npulse  in  NW  number of echo pulses.
- cfg_block_off  in  CW  inhibit extension after the last pulse.
- cfg_pre_att  in  AW  attenuator code during the sequence.
- cfg_post_att  in  AW  attenuator code after the sequence.
- sync_out  out  1  period marker.
- pulse_out  out  1  switch drive.
- inhib_out  out  1  receiver blanking.
- att_out  out  AW  attenuator code.
- cycle_done  out  1  one-cycle strobe in the last cycle of each period.
- err_overrun  out  1  sticky: the sequence did not fit in the period.

Behaviour:
- Reset: resetn is synchronous and active-low on clk. Reset clears the counter, state, and both config sets to 0. All outputs are 0.
- Counter and period:
  - Period counter cnt runs 0..period-1, then wraps to 0. Period start is cnt==0.
  - Active config is copied from shadow at every wrap, and whenever the block is idle.
  - A cfg_load in the same cycle as a wrap is captured into shadow and takes effect at the following wrap.
- Idle conditions: enable low, or active period < 2.
  - Block is IDLE: cnt held at 0, all outputs 0 (err_overrun holds its value).
  - When enable rises (with a valid period), cycle 0 is the first cycle after the rise.
- State machine (advances on internal down-counters):
  - P1 (p1width cycles), GAP (delay), then repeated [P2 (p2width), GAP2 (2*delay)].
  - P2 runs npulse times; the final GAP2 is omitted. Then WAIT until wrap.
  - Any state whose length is 0 is skipped with no idle cycle. npulse=0 means no echoes, so GAP is also skipped.
  - 2*delay is computed at CW+1 bits with no overflow.
- Outputs (all registered; "cycle k" means the cycle with cnt==k):
  - pulse_out: high in P1 and P2.
  - sync_out: high for cycles 0..min(SYNC_W, period)-1.
  - inhib_out: high from cycle 0 through the last pulse's final cycle + cfg_block_off, clipped at wrap.
  - att_out: equals pre_att from cycle 0 through the last pulse's final cycle, then post_att until wrap.
  - If the sequence has no pulses: inhib_out is high only for block_off cycles from 0, and att_out = post_att.
- Overrun: if wrap occurs before WAIT is reached, the sequence is aborted. The FSM restarts at P1 on cycle 0 and err_overrun is set.
  - err_overrun clears only on cfg_load or reset.
- Disable mid-period: enable low takes effect on the next edge: IDLE, outputs 0, no cycle_done.
- Reset mid-period: same as the reset state; config is lost.

Optional Feature:
- Macro: PULSE_PHASE_EN.
- When defined:
  - Adds output port phase_out [1:0] and input cfg_alt [1].
  - phase_out = 0 during P1. Echo k (k from 0) gets phase 1, or 3 when cfg_alt=1 and k is odd.
  - phase_out is held from the start of a pulse until the start of the next pulse, so phase is settled before each pulse edge. It is 0 in WAIT and IDLE.
  - cfg_alt is double-buffered like the other cfg_* fields.
- When undefined: neither port exists and there is no phase logic.

Test Plan:
- Base sequence: load period=100, p1width=3, delay=5, p2width=6, npulse=2, block_off=4, pre=0, post=7F; then enable.
  - pulse_out high in cycles 0-2, 8-13, 24-29.
  - inhib_out high 0-33.
  - att_out=0 for 0-29, 7F for 30-99.
  - sync_out high 0-15.
  - cycle_done at cycle 99; err_overrun=0.
- Overrun: same config with period=20.
  - pulse_out high 0-2, 8-13, then low 14-19.
  - err_overrun=1 from wrap; next period starts identically at cycle 0.
  - A further cfg_load clears err_overrun.
- Double-buffering: with the base config running, assert cfg_load at cycle 50 with p1width=10.
  - Current period is unchanged.
  - Next period pulse_out is high 0-9, echoes at 15-20 and 31-36.
- Zero fields: npulse=0, p1width=0, block_off=4.
  - pulse_out is never high.
  - inhib_out high 0-3; att_out=post_att throughout.
- Enable and reset mid-period:
  - Drop enable at cycle 10: all outputs 0 at the next edge, and the period restarts at cycle 0 after re-enable.
  - Assert resetn=0 at cycle 10: outputs 0; after release, nothing is generated until cfg_load.
- PULSE_PHASE_EN with cfg_alt=1, npulse=4: phase_out sequence 0,1,3,1,3 aligned to each pulse start.
